// File: rtl/fp25519_pkg.sv
// rtl/fp25519_pkg.sv - field constants and FSM state type for the GF(2^255-19) inverter.
package fp25519_pkg;

  localparam int WIDTH = 255;

  localparam logic [WIDTH-1:0] P =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // (p+1)/2: added to x>>1 when x is odd, so (x+p)/2 never needs a 256th bit
  localparam logic [WIDTH-1:0] P_HALF_UP = (P >> 1) + ONE;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    DONE
  } state_e;

endpackage

// File: rtl/fp_half.sv
// rtl/fp_half.sv - combinational halving modulo p for an input already below p.
module fp_half
  import fp25519_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // odd x: (x+p)/2 == (x>>1) + (p+1)/2, which stays below p
  assign y = (x >> 1) + (x[0] ? P_HALF_UP : '0);

endmodule

// File: rtl/fp25519_inv.sv
// rtl/fp25519_inv.sv - sequential binary extended Euclid inverter, a^-1 mod (2^255-19).
module fp25519_inv
  import fp25519_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_inv,
  output logic             out_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] x1_half, x2_half;
  logic [WIDTH-1:0] a_red;
  logic             u_ge_v;
  logic [WIDTH-1:0] uv_diff;
  logic [WIDTH-1:0] sub_a, sub_b, mod_diff;

  fp_half u_half_x1 (.x(x1_q), .y(x1_half));
  fp_half u_half_x2 (.x(x2_q), .y(x2_half));

  // u_q holds the raw operand during LOAD; one conditional subtract reduces it
  assign a_red   = (u_q >= P) ? u_q - P : u_q;
  assign u_ge_v  = (u_q >= v_q);
  assign uv_diff = u_ge_v ? u_q - v_q : v_q - u_q;

  // shared modular subtract; when sub_a < sub_b the wrap of sub_a-sub_b+p lands in [0,p)
  assign sub_a    = u_ge_v ? x1_q : x2_q;
  assign sub_b    = u_ge_v ? x2_q : x1_q;
  assign mod_diff = sub_a - sub_b + ((sub_a >= sub_b) ? '0 : P);

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          u_d     = in_a;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (a_red == '0) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          u_d     = a_red;
          v_d     = P;
          x1_d    = ONE;
          x2_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = STEP;
        end
      end

      STEP: begin
        if (cnt_q == CNT_MAX) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (u_q == ONE) begin
          res_d   = x1_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (v_q == ONE) begin
          res_d   = x2_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = x1_half;
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = x2_half;
          end else if (u_ge_v) begin
            u_d  = uv_diff;
            x1_d = mod_diff;
          end else begin
            v_d  = uv_diff;
            x2_d = mod_diff;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_inv   = res_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_fp25519_inv.sv
// tb/tb_fp25519_inv.sv - directed-vector bench for fp25519_inv with a modular-product scoreboard.
module tb_fp25519_inv;

  localparam logic [254:0] P =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [254:0] INV2 =
    255'h3fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff7;
  localparam logic [254:0] INV3 =
    255'h55555555_55555555_55555555_55555555_55555555_55555555_55555555_55555549;
  localparam logic [254:0] INV5 =
    255'h19999999_99999999_99999999_99999999_99999999_99999999_99999999_99999996;
  localparam logic [254:0] A_BIG =
    255'h12345678_9abcdef0_12345678_9abcdef0_12345678_9abcdef0_12345678_9abcdef0;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [254:0] in_a;
  logic         out_valid;
  logic         out_ready;
  logic [254:0] out_inv;
  logic         out_err;
  logic         busy;

  int errors;
  int checks;

  fp25519_inv dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inv  (out_inv),
    .out_err  (out_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] prod;
    prod = {257'b0, a} * {257'b0, b};
    prod = prod % {257'b0, P};
    return prod[254:0];
  endfunction

  task automatic start_op(input logic [254:0] a);
    @(negedge clk);
    in_a     = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat counts the accept cycle as cycle 1
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 1200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("timeout", {255'b0, out_valid}, 256'd1);
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [254:0] a, output logic [254:0] inv, output logic err,
                       output int lat);
    start_op(a);
    wait_valid(lat);
    inv = out_inv;
    err = out_err;
    take_result();
  endtask

  initial begin
    logic [254:0] inv, ra, held_inv;
    logic         err, held_err;
    logic [255:0] rw;
    int           lat, max_steps, unstable, bad_ready;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {255'b0, in_ready}, 256'd1);
    check("rst_out_valid", {255'b0, out_valid}, 256'd0);
    check("rst_out_inv", {1'b0, out_inv}, 256'd0);
    check("rst_out_err", {255'b0, out_err}, 256'd0);
    check("rst_busy", {255'b0, busy}, 256'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(255'd1, inv, err, lat);
    check("a1_inv", {1'b0, inv}, 256'd1);
    check("a1_err", {255'b0, err}, 256'd0);
    check("a1_latency", 256'(lat), 256'd3);

    do_op(255'd2, inv, err, lat);
    check("a2_inv", {1'b0, inv}, {1'b0, INV2});
    check("a2_model", {1'b0, mulmod(255'd2, inv)}, 256'd1);

    do_op(P - 255'd1, inv, err, lat);
    check("pm1_inv", {1'b0, inv}, {1'b0, P - 255'd1});

    do_op(255'd3, inv, err, lat);
    check("a3_inv", {1'b0, inv}, {1'b0, INV3});
    check("a3_model", {1'b0, mulmod(255'd3, inv)}, 256'd1);

    do_op(255'd0, inv, err, lat);
    check("a0_inv", {1'b0, inv}, 256'd0);
    check("a0_err", {255'b0, err}, 256'd1);

    do_op(P, inv, err, lat);
    check("ap_err", {255'b0, err}, 256'd1);
    check("ap_inv", {1'b0, inv}, 256'd0);

    do_op(P + 255'd1, inv, err, lat);
    check("ap1_inv", {1'b0, inv}, 256'd1);
    check("ap1_err", {255'b0, err}, 256'd0);

    max_steps = 0;
    for (int n = 0; n < 24; n++) begin
      for (int w = 0; w < 8; w++) rw[w*32 +: 32] = $urandom;
      ra = rw[254:0];
      if (ra >= P) ra = ra - P;
      if (ra == '0) ra = 255'd1;
      do_op(ra, inv, err, lat);
      check("rand_prod", {1'b0, mulmod(ra, inv)}, 256'd1);
      check("rand_err", {255'b0, err}, 256'd0);
      if (lat - 2 > max_steps) max_steps = lat - 2;
    end
    check("max_steps_le_800", 256'(max_steps <= 800), 256'd1);

    // backpressure: hold the result and poke in_valid while in DONE
    start_op(255'd7);
    wait_valid(lat);
    held_inv  = out_inv;
    held_err  = out_err;
    unstable  = 0;
    bad_ready = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = (c == 5);
      in_a     = 255'd9;
      @(posedge clk);
      #1;
      if (out_inv !== held_inv || out_err !== held_err || !out_valid) unstable++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    in_valid = 1'b0;
    check("bp_stable", 256'(unstable), 256'd0);
    check("bp_in_ready_low", 256'(bad_ready), 256'd0);
    check("bp_a7_prod", {1'b0, mulmod(255'd7, held_inv)}, 256'd1);
    take_result();
    check("bp_in_ready_after", {255'b0, in_ready}, 256'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_pulse_ignored", {255'b0, busy}, 256'd0);

    // reset in the middle of a long STEP run
    start_op(A_BIG);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {255'b0, in_ready}, 256'd1);
    check("mid_rst_out_valid", {255'b0, out_valid}, 256'd0);
    check("mid_rst_out_inv", {1'b0, out_inv}, 256'd0);
    check("mid_rst_out_err", {255'b0, out_err}, 256'd0);
    check("mid_rst_busy", {255'b0, busy}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale", {255'b0, out_valid}, 256'd0);
    do_op(255'd5, inv, err, lat);
    check("a5_inv", {1'b0, inv}, {1'b0, INV5});
    check("a5_model", {1'b0, mulmod(255'd5, inv)}, 256'd1);
    check("a5_err", {255'b0, err}, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
